// File: rtl/spatz_xmem_adapter.sv
// Bridges the Spatz VLSU X-interface memory port to a TCDM-style port with
// credit limiting and in-order ID tracking. Optional macro SPATZ_XMEM_RSP_REG_EN registers the result path.
module spatz_xmem_adapter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   x_mem_valid_i,
  output logic                   x_mem_ready_o,
  input  logic [AddrWidth-1:0]   x_mem_addr_i,
  input  logic                   x_mem_we_i,
  input  logic [DataWidth/8-1:0] x_mem_be_i,
  input  logic [DataWidth-1:0]   x_mem_wdata_i,
  input  logic [IdWidth-1:0]     x_mem_id_i,
  output logic                   x_mem_result_valid_o,
  output logic [DataWidth-1:0]   x_mem_result_rdata_o,
  output logic [IdWidth-1:0]     x_mem_result_id_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic [CntW-1:0]        outstanding_o,
  output logic                   idle_o,
  output logic                   err_o
);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic [CntW-1:0]           r_cnt;
  logic [PtrW-1:0]           r_wptr, r_rptr;
  logic                      r_err;
  logic [IdWidth-1:0]        r_meta_id [MaxOutstanding];
  logic [MaxOutstanding-1:0] r_meta_we;

  logic w_credit, w_push, w_pop, w_spur, w_res_valid;
  logic [IdWidth-1:0]   w_res_id;
  logic [DataWidth-1:0] w_res_rdata;

  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Credit comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign w_credit = (r_cnt < MaxCnt);
  assign w_push   = x_mem_valid_i & mem_gnt_i & w_credit;
  assign w_pop    = mem_rvalid_i & (r_cnt != '0);
  assign w_spur   = mem_rvalid_i & (r_cnt == '0);

  assign mem_req_o     = x_mem_valid_i & w_credit;
  assign x_mem_ready_o = mem_gnt_i & w_credit;
  assign mem_addr_o    = x_mem_addr_i;
  assign mem_we_o      = x_mem_we_i;
  assign mem_be_o      = x_mem_be_i;
  assign mem_wdata_o   = x_mem_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CntW'(1);
      if (w_spur) r_err <= 1'b1;
    end
  end

  // Metadata storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_meta_id[r_wptr] <= x_mem_id_i;
      r_meta_we[r_wptr] <= x_mem_we_i;
    end
  end

  assign w_res_valid = w_pop & ~r_meta_we[r_rptr];
  assign w_res_rdata = w_res_valid ? mem_rdata_i : '0;
  assign w_res_id    = w_res_valid ? r_meta_id[r_rptr] : '0;

  assign outstanding_o = r_cnt;
  assign err_o         = r_err;

`ifdef SPATZ_XMEM_RSP_REG_EN
  logic                 r_res_valid;
  logic [DataWidth-1:0] r_res_rdata;
  logic [IdWidth-1:0]   r_res_id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid <= 1'b0;
      r_res_rdata <= '0;
      r_res_id    <= '0;
    end else begin
      r_res_valid <= w_res_valid;
      r_res_rdata <= w_res_rdata;
      r_res_id    <= w_res_id;
    end
  end

  assign x_mem_result_valid_o = r_res_valid;
  assign x_mem_result_rdata_o = r_res_rdata;
  assign x_mem_result_id_o    = r_res_id;
  assign idle_o               = (r_cnt == '0) & ~r_res_valid;
`else
  assign x_mem_result_valid_o = w_res_valid;
  assign x_mem_result_rdata_o = w_res_rdata;
  assign x_mem_result_id_o    = w_res_id;
  assign idle_o               = (r_cnt == '0);
`endif

endmodule
